// File: rtl/aes_ctr_pkg.sv
// aes_ctr_pkg: register map offsets, word counts, FSM states and response
// codes shared by the AES-CTR AXI4-Lite register block.
package aes_ctr_pkg;

  // Byte offsets within the 256 B peripheral window
  localparam int unsigned OFF_START = 32'h00;
  localparam int unsigned OFF_PT    = 32'h04;
  localparam int unsigned OFF_KEY0  = 32'h14;
  localparam int unsigned OFF_DONE  = 32'h2C;
  localparam int unsigned OFF_CT    = 32'h30;
  localparam int unsigned OFF_ST    = 32'h40;
  localparam int unsigned OFF_KEY1  = 32'h50;
  localparam int unsigned OFF_KEY2  = 32'h68;
  localparam int unsigned OFF_KSEL  = 32'h80;
  localparam int unsigned OFF_IRQEN = 32'h84;

  // Word counts of the multi-word registers
  localparam int unsigned PT_WORDS  = 4;
  localparam int unsigned CT_WORDS  = 4;
  localparam int unsigned ST_WORDS  = 4;
  localparam int unsigned KEY_WORDS = 6;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_FINISH = 2'd3
  } fsm_e;

  // Byte-lane merge of a bus write into an existing word
  function automatic logic [31:0] apply_strb(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    r = old_w;
    for (int unsigned b = 0; b < 4; b++) begin
      if (strb[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_ctr_axil_slave.sv
// aes_ctr_axil_slave: AXI4-Lite channel handshakes. AW and W are captured
// independently; one write is outstanding at a time; reads are registered.
module aes_ctr_axil_slave
  import aes_ctr_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic [ADDR_W-1:0] s_awaddr,
  input  logic              s_awvalid,
  output logic              s_awready,
  input  logic [31:0]       s_wdata,
  input  logic [3:0]        s_wstrb,
  input  logic              s_wvalid,
  output logic              s_wready,
  output logic [1:0]        s_bresp,
  output logic              s_bvalid,
  input  logic              s_bready,
  input  logic [ADDR_W-1:0] s_araddr,
  input  logic              s_arvalid,
  output logic              s_arready,
  output logic [31:0]       s_rdata,
  output logic [1:0]        s_rresp,
  output logic              s_rvalid,
  input  logic              s_rready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [3:0]        wr_strb,
  input  logic              wr_err,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [31:0]       rd_data,
  input  logic              rd_err
);

  logic [ADDR_W-1:0] awaddr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        wstrb_q;
  logic aw_got_q, w_got_q, awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
  logic aw_got_d, w_got_d, awready_d, wready_d, bvalid_d, arready_d, rvalid_d;
  logic [1:0]  bresp_q, rresp_q;
  logic [31:0] rdata_q;
  logic aw_hs, w_hs, ar_hs;

  assign wr_addr   = awaddr_q;
  assign wr_data   = wdata_q;
  assign wr_strb   = wstrb_q;
  assign rd_en     = ar_hs;
  assign rd_addr   = s_araddr;
  assign s_awready = awready_q;
  assign s_wready  = wready_q;
  assign s_bvalid  = bvalid_q;
  assign s_bresp   = bresp_q;
  assign s_arready = arready_q;
  assign s_rvalid  = rvalid_q;
  assign s_rdata   = rdata_q;
  assign s_rresp   = rresp_q;

  // Next-state of handshake flags; readies are registered so they stay low in reset
  always_comb begin
    aw_hs     = s_awvalid & awready_q;
    w_hs      = s_wvalid & wready_q;
    ar_hs     = s_arvalid & arready_q;
    wr_en     = aw_got_q & w_got_q;
    aw_got_d  = wr_en ? 1'b0 : (aw_got_q | aw_hs);
    w_got_d   = wr_en ? 1'b0 : (w_got_q | w_hs);
    bvalid_d  = wr_en ? 1'b1 : (bvalid_q & ~s_bready);
    awready_d = ~aw_got_d & ~bvalid_d;
    wready_d  = ~w_got_d & ~bvalid_d;
    rvalid_d  = ar_hs | (rvalid_q & ~s_rready);
    arready_d = ~rvalid_d;
  end

  // Channel state, captured write beat and registered read response
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_got_q  <= 1'b0;
      w_got_q   <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      if (aw_hs) awaddr_q <= s_awaddr;
      if (w_hs) begin
        wdata_q <= s_wdata;
        wstrb_q <= s_wstrb;
      end
      if (wr_en) bresp_q <= wr_err ? RESP_SLVERR : RESP_OKAY;
      if (ar_hs) begin
        rdata_q <= rd_data;
        rresp_q <= rd_err ? RESP_SLVERR : RESP_OKAY;
      end
      aw_got_q  <= aw_got_d;
      w_got_q   <= w_got_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
    end
  end

endmodule

// File: rtl/aes_ctr_axil_regs.sv
// aes_ctr_axil_regs: AES-CTR register map, storage and block-launch FSM.
// Optional AES_CTR_IRQ_EN adds the irq output, IRQ_EN at 0x84 and W1C DONE.
module aes_ctr_axil_regs
  import aes_ctr_pkg::*;
#(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned KEY_BITS = 192
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic [ADDR_W-1:0]   s_awaddr,
  input  logic                s_awvalid,
  output logic                s_awready,
  input  logic [31:0]         s_wdata,
  input  logic [3:0]          s_wstrb,
  input  logic                s_wvalid,
  output logic                s_wready,
  output logic [1:0]          s_bresp,
  output logic                s_bvalid,
  input  logic                s_bready,
  input  logic [ADDR_W-1:0]   s_araddr,
  input  logic                s_arvalid,
  output logic                s_arready,
  output logic [31:0]         s_rdata,
  output logic [1:0]          s_rresp,
  output logic                s_rvalid,
  input  logic                s_rready,
`ifdef AES_CTR_IRQ_EN
  output logic                irq,
`endif
  output logic                core_start,
  output logic [KEY_BITS-1:0] core_key,
  output logic [127:0]        core_block,
  input  logic                core_done,
  input  logic [127:0]        core_result
);

  localparam int unsigned KW  = KEY_BITS / 32;
  localparam int unsigned KWW = $clog2(KW);
`ifdef AES_CTR_IRQ_EN
  localparam int unsigned LAST_W = OFF_IRQEN / 4;
`else
  localparam int unsigned LAST_W = OFF_KSEL / 4;
`endif

  logic              wr_en, wr_err, rd_en, rd_err;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [31:0]       wr_data, rd_data;
  logic [3:0]        wr_strb;

  logic [31:0]   pt_q [PT_WORDS];
  logic [31:0]   ct_q [CT_WORDS];
  logic [31:0]   st_q [ST_WORDS];
  logic [31:0]   key_q [3][KW];
  logic [1:0]    ksel_q;
  logic          start_q, done_q, core_start_q;
  logic [KEY_BITS-1:0] core_key_q, sel_key;
  logic [127:0]  core_block_q, res_q, st_vec, st_inc;
  logic [1:0]    kidx;
  fsm_e          state_q;
  int unsigned   wi, ri;
  logic          start_req;
`ifdef AES_CTR_IRQ_EN
  logic          irq_en_q, irq_q;
  assign irq = irq_q;
`endif

  assign core_start = core_start_q;
  assign core_key   = core_key_q;
  assign core_block = core_block_q;

  function automatic int unsigned widx(input logic [ADDR_W-1:0] a);
    return 32'(a >> 2);
  endfunction

  function automatic logic in_rng(input int unsigned w, input int unsigned off,
                                  input int unsigned n);
    return (w >= off / 4) && (w < off / 4 + n);
  endfunction

  aes_ctr_axil_slave #(.ADDR_W(ADDR_W)) u_slave (
    .aclk(aclk), .areset(areset),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
    .wr_err(wr_err), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_err(rd_err)
  );

  // Address decode, key selection and counter assembly
  always_comb begin
    wi        = widx(wr_addr);
    ri        = widx(rd_addr);
    wr_err    = (wi > LAST_W);
    start_req = wr_en && !wr_err && (wi == OFF_START / 4) && wr_strb[0] &&
                wr_data[0] && !start_q;
    kidx      = (ksel_q == 2'd3) ? 2'd0 : ksel_q;
    sel_key   = '0;
    for (int unsigned i = 0; i < KW; i++) sel_key[i*32 +: 32] = key_q[kidx][i];
    st_vec = '0;
    for (int unsigned i = 0; i < ST_WORDS; i++) st_vec[i*32 +: 32] = st_q[i];
    st_inc = core_block_q + 128'd1;
  end

  // Read mux; sampled by the slave on the AR handshake, so it sees pre-write values
  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    if (rd_en) begin
      rd_err = (ri > LAST_W);
      if (ri == OFF_START / 4)                rd_data = {31'd0, start_q};
      else if (in_rng(ri, OFF_PT, PT_WORDS))  rd_data = pt_q[2'(ri - OFF_PT / 4)];
      else if (in_rng(ri, OFF_KEY0, KW))      rd_data = key_q[0][KWW'(ri - OFF_KEY0 / 4)];
      else if (ri == OFF_DONE / 4)            rd_data = {31'd0, done_q};
      else if (in_rng(ri, OFF_CT, CT_WORDS))  rd_data = ct_q[2'(ri - OFF_CT / 4)];
      else if (in_rng(ri, OFF_ST, ST_WORDS))  rd_data = st_q[2'(ri - OFF_ST / 4)];
      else if (in_rng(ri, OFF_KEY1, KW))      rd_data = key_q[1][KWW'(ri - OFF_KEY1 / 4)];
      else if (in_rng(ri, OFF_KEY2, KW))      rd_data = key_q[2][KWW'(ri - OFF_KEY2 / 4)];
      else if (ri == OFF_KSEL / 4)            rd_data = {30'd0, ksel_q};
`ifdef AES_CTR_IRQ_EN
      else if (ri == OFF_IRQEN / 4)           rd_data = {31'd0, irq_en_q};
`endif
    end
  end

  // FSM and register storage; bus writes follow the FSM so an ST write in FINISH wins
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q      <= S_IDLE;
      start_q      <= 1'b0;
      done_q       <= 1'b0;
      ksel_q       <= '0;
      core_start_q <= 1'b0;
      core_key_q   <= '0;
      core_block_q <= '0;
      res_q        <= '0;
      for (int unsigned i = 0; i < PT_WORDS; i++) pt_q[i] <= '0;
      for (int unsigned i = 0; i < CT_WORDS; i++) ct_q[i] <= '0;
      for (int unsigned i = 0; i < ST_WORDS; i++) st_q[i] <= '0;
      for (int unsigned k = 0; k < 3; k++)
        for (int unsigned i = 0; i < KW; i++) key_q[k][i] <= '0;
`ifdef AES_CTR_IRQ_EN
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
`endif
    end else begin
      core_start_q <= 1'b0;
      unique case (state_q)
        S_IDLE: if (start_req) begin
          core_key_q   <= sel_key;
          core_block_q <= st_vec;
          state_q      <= S_LAUNCH;
        end
        S_LAUNCH: begin
          core_start_q <= 1'b1;
          done_q       <= 1'b0;
          state_q      <= S_WAIT;
        end
        S_WAIT: if (core_done) begin
          res_q   <= core_result;
          state_q <= S_FINISH;
        end
        S_FINISH: begin
          for (int unsigned i = 0; i < CT_WORDS; i++) ct_q[i] <= res_q[i*32 +: 32] ^ pt_q[i];
          for (int unsigned i = 0; i < ST_WORDS; i++) st_q[i] <= st_inc[i*32 +: 32];
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
`ifdef AES_CTR_IRQ_EN
      irq_q <= done_q & irq_en_q;
`endif
      if (wr_en && !wr_err) begin
        if (wi == OFF_START / 4) begin
          if (wr_strb[0]) start_q <= wr_data[0];
        end else if (in_rng(wi, OFF_PT, PT_WORDS))
          pt_q[2'(wi - OFF_PT / 4)] <= apply_strb(pt_q[2'(wi - OFF_PT / 4)], wr_data, wr_strb);
        else if (in_rng(wi, OFF_KEY0, KW))
          key_q[0][KWW'(wi - OFF_KEY0 / 4)] <=
            apply_strb(key_q[0][KWW'(wi - OFF_KEY0 / 4)], wr_data, wr_strb);
        else if (in_rng(wi, OFF_ST, ST_WORDS))
          st_q[2'(wi - OFF_ST / 4)] <= apply_strb(st_q[2'(wi - OFF_ST / 4)], wr_data, wr_strb);
        else if (in_rng(wi, OFF_KEY1, KW))
          key_q[1][KWW'(wi - OFF_KEY1 / 4)] <=
            apply_strb(key_q[1][KWW'(wi - OFF_KEY1 / 4)], wr_data, wr_strb);
        else if (in_rng(wi, OFF_KEY2, KW))
          key_q[2][KWW'(wi - OFF_KEY2 / 4)] <=
            apply_strb(key_q[2][KWW'(wi - OFF_KEY2 / 4)], wr_data, wr_strb);
        else if (wi == OFF_KSEL / 4) begin
          if (wr_strb[0]) ksel_q <= wr_data[1:0];
        end
`ifdef AES_CTR_IRQ_EN
        else if (wi == OFF_IRQEN / 4) begin
          if (wr_strb[0]) irq_en_q <= wr_data[0];
        end else if (wi == OFF_DONE / 4) begin
          if (wr_strb[0] && wr_data[0]) done_q <= 1'b0;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_aes_ctr_axil_regs.sv
// tb_aes_ctr_axil_regs: directed bench for the AES-CTR register block with a
// simple core model that answers all-ones a fixed number of cycles after start.
module tb_aes_ctr_axil_regs;

  logic         aclk = 1'b0;
  logic         areset = 1'b1;
  logic [7:0]   s_awaddr = '0, s_araddr = '0;
  logic         s_awvalid = 1'b0, s_wvalid = 1'b0, s_bready = 1'b0;
  logic         s_arvalid = 1'b0, s_rready = 1'b0;
  logic [31:0]  s_wdata = '0;
  logic [3:0]   s_wstrb = '0;
  logic         s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
  logic [1:0]   s_bresp, s_rresp;
  logic [31:0]  s_rdata;
  logic         core_start;
  logic [191:0] core_key;
  logic [127:0] core_block;
  logic         core_done = 1'b0;
  logic [127:0] core_result = '0;
`ifdef AES_CTR_IRQ_EN
  logic         irq;
`endif

  int total = 0;
  int bad = 0;
  int n_start = 0;
  int n_done = 0;
  int core_lat = 5;
  logic [191:0] cap_key = '0;
  logic [127:0] cap_block = '0;

  always #5 aclk = ~aclk;

  aes_ctr_axil_regs #(.ADDR_W(8), .KEY_BITS(192)) dut (
    .aclk(aclk), .areset(areset),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
`ifdef AES_CTR_IRQ_EN
    .irq(irq),
`endif
    .core_start(core_start), .core_key(core_key), .core_block(core_block),
    .core_done(core_done), .core_result(core_result)
  );

  always @(negedge aclk) begin
    if (core_start) begin
      n_start   <= n_start + 1;
      cap_key   <= core_key;
      cap_block <= core_block;
    end
    if (core_done) n_done <= n_done + 1;
  end

  initial begin
    forever begin
      @(negedge aclk);
      if (core_start) begin
        repeat (core_lat) @(negedge aclk);
        #1 core_done = 1'b1; core_result = '1;
        @(negedge aclk);
        #1 core_done = 1'b0; core_result = '0;
      end
    end
  end

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic axi_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] st,
                        output logic [1:0] resp);
    logic awd, wd, hsa, hsw, bd;
    int n;
    @(negedge aclk);
    s_awaddr = a; s_awvalid = 1'b1; s_wdata = d; s_wstrb = st; s_wvalid = 1'b1;
    awd = 1'b0; wd = 1'b0; bd = 1'b0; n = 0; resp = 2'bxx;
    while (!(awd && wd) && n < 50) begin
      hsa = s_awvalid & s_awready;
      hsw = s_wvalid & s_wready;
      @(posedge aclk); #1;
      if (hsa) begin s_awvalid = 1'b0; awd = 1'b1; end
      if (hsw) begin s_wvalid = 1'b0; wd = 1'b1; end
      @(negedge aclk); n++;
    end
    s_bready = 1'b1;
    n = 0;
    while (!bd && n < 50) begin
      if (s_bvalid) begin resp = s_bresp; bd = 1'b1; end
      @(posedge aclk); #1;
      if (!bd) begin @(negedge aclk); n++; end
    end
    s_bready = 1'b0; s_awvalid = 1'b0; s_wvalid = 1'b0;
    chk("wr_handshake", {191'd0, awd & wd & bd}, 192'd1);
  endtask

  task automatic axi_rd(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp);
    logic ard, rd, hs;
    int n;
    @(negedge aclk);
    s_araddr = a; s_arvalid = 1'b1; ard = 1'b0; rd = 1'b0; n = 0;
    d = 'x; resp = 2'bxx;
    while (!ard && n < 50) begin
      hs = s_arvalid & s_arready;
      @(posedge aclk); #1;
      if (hs) begin s_arvalid = 1'b0; ard = 1'b1; end
      @(negedge aclk); n++;
    end
    s_rready = 1'b1; n = 0;
    while (!rd && n < 50) begin
      if (s_rvalid) begin d = s_rdata; resp = s_rresp; rd = 1'b1; end
      @(posedge aclk); #1;
      if (!rd) begin @(negedge aclk); n++; end
    end
    s_rready = 1'b0; s_arvalid = 1'b0;
    chk("rd_handshake", {191'd0, ard & rd}, 192'd1);
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp_d,
                        input logic [1:0] exp_r);
    logic [31:0] d;
    logic [1:0]  r;
    axi_rd(a, d, r);
    chk({tag, "_data"}, {160'd0, d}, {160'd0, exp_d});
    chk({tag, "_resp"}, {190'd0, r}, {190'd0, exp_r});
  endtask

  // START 0 then 1, then wait for the launch and for the core's answer
  task automatic run_block();
    logic [1:0] r;
    int s0, d0, n;
    s0 = n_start; d0 = n_done;
    axi_wr(8'h00, 32'h0, 4'h1, r);
    axi_wr(8'h00, 32'h1, 4'h1, r);
    n = 0;
    while (n_start == s0 && n < 50) begin @(negedge aclk); n++; end
    chk("launch_seen", {191'd0, n_start != s0}, 192'd1);
    n = 0;
    while (n_done == d0 && n < 200) begin @(negedge aclk); n++; end
    chk("done_seen", {191'd0, n_done != d0}, 192'd1);
    repeat (4) @(negedge aclk);
  endtask

  initial begin
    logic [1:0]  r;
    logic [31:0] d;
    logic        stable, hs;
    int s0, d0, n;

    repeat (3) @(negedge aclk);
    chk("reset_outs", {186'd0, s_awready, s_wready, s_bvalid, s_arready, s_rvalid, core_start},
        192'd0);
    chk("reset_key", core_key, 192'd0);
    areset = 1'b0;
    @(posedge aclk); #1;
    chk("ready_after_reset", {190'd0, s_awready, s_arready}, 192'd3);

    rd_chk("rd_done0", 8'h2C, 32'h0, 2'b00);
    rd_chk("rd_ct0",   8'h30, 32'h0, 2'b00);
    rd_chk("rd_ksel0", 8'h80, 32'h0, 2'b00);
    rd_chk("rd_unmap", 8'h90, 32'h0, 2'b10);
`ifndef AES_CTR_IRQ_EN
    rd_chk("rd_84", 8'h84, 32'h0, 2'b10);
`endif

    axi_wr(8'h90, 32'hFFFF_FFFF, 4'hF, r);
    chk("wr_unmap_resp", {190'd0, r}, {190'd0, 2'b10});
    axi_wr(8'h2C, 32'h1, 4'hF, r);
    chk("wr_ro_resp", {190'd0, r}, 192'd0);
    rd_chk("rd_done_ro", 8'h2C, 32'h0, 2'b00);

    axi_wr(8'h04, 32'hAABB_CCDD, 4'b0010, r);
    rd_chk("strb", 8'h04, 32'h0000_CC00, 2'b00);

    // AW three cycles ahead of W, then BREADY held low while a second beat waits
    @(negedge aclk);
    s_awaddr = 8'h08; s_awvalid = 1'b1; hs = 1'b0; n = 0;
    while (!hs && n < 20) begin
      hs = s_awready;
      @(posedge aclk); #1;
      if (hs) s_awvalid = 1'b0;
      @(negedge aclk); n++;
    end
    repeat (3) @(negedge aclk);
    s_wdata = 32'h1234_5678; s_wstrb = 4'hF; s_wvalid = 1'b1; hs = 1'b0; n = 0;
    while (!hs && n < 20) begin
      hs = s_wready;
      @(posedge aclk); #1;
      if (hs) s_wvalid = 1'b0;
      @(negedge aclk); n++;
    end
    n = 0;
    while (!s_bvalid && n < 20) begin @(negedge aclk); n++; end
    s_awaddr = 8'h0C; s_awvalid = 1'b1; s_wdata = 32'hDEAD_BEEF; s_wvalid = 1'b1;
    stable = 1'b1;
    repeat (4) begin
      if (!(s_bvalid && !s_awready && !s_wready)) stable = 1'b0;
      @(negedge aclk);
    end
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    chk("stag_stable", {191'd0, stable}, 192'd1);
    s_bready = 1'b1;
    @(posedge aclk); #1;
    s_bready = 1'b0;
    rd_chk("stag_word1", 8'h08, 32'h1234_5678, 2'b00);
    rd_chk("stag_word2", 8'h0C, 32'h0, 2'b00);

    for (int i = 0; i < 6; i++) axi_wr(8'(8'h50 + 4 * i), 32'h1111_1111 * (i + 1), 4'hF, r);
    axi_wr(8'h80, 32'h1, 4'hF, r);
    run_block();
    chk("key1_at_start", cap_key,
        192'h666666665555555544444444333333332222222211111111);

    axi_wr(8'h04, 32'h6666_7777, 4'hF, r);
    axi_wr(8'h08, 32'h4444_5555, 4'hF, r);
    axi_wr(8'h0C, 32'h2222_3333, 4'hF, r);
    axi_wr(8'h10, 32'h0000_1111, 4'hF, r);
    axi_wr(8'h40, 32'he037_0734, 4'hF, r);
    axi_wr(8'h44, 32'h3131_98a2, 4'hF, r);
    axi_wr(8'h48, 32'h885a_308d, 4'hF, r);
    axi_wr(8'h4C, 32'h3243_f6a8, 4'hF, r);
    run_block();
    chk("block_at_start", {64'd0, cap_block}, {64'd0, 128'h3243f6a8885a308d313198a2e0370734});
    rd_chk("done1", 8'h2C, 32'h1, 2'b00);
    rd_chk("ct0", 8'h30, 32'h9999_8888, 2'b00);
    rd_chk("ct1", 8'h34, 32'hBBBB_AAAA, 2'b00);
    rd_chk("ct2", 8'h38, 32'hDDDD_CCCC, 2'b00);
    rd_chk("ct3", 8'h3C, 32'hFFFF_EEEE, 2'b00);
    rd_chk("st0_inc", 8'h40, 32'he037_0735, 2'b00);
    rd_chk("st3_keep", 8'h4C, 32'h3243_f6a8, 2'b00);

    for (int i = 0; i < 4; i++) axi_wr(8'(8'h40 + 4 * i), 32'hFFFF_FFFF, 4'hF, r);
    run_block();
    for (int i = 0; i < 4; i++) begin
      axi_rd(8'(8'h40 + 4 * i), d, r);
      chk("st_wrap", {160'd0, d}, 192'd0);
    end

    core_lat = 40;
    s0 = n_start; d0 = n_done;
    axi_wr(8'h00, 32'h0, 4'h1, r);
    axi_wr(8'h00, 32'h1, 4'h1, r);
    n = 0;
    while (n_start == s0 && n < 50) begin @(negedge aclk); n++; end
    axi_wr(8'h00, 32'h0, 4'h1, r);
    axi_wr(8'h00, 32'h1, 4'h1, r);
    n = 0;
    while (n_done == d0 && n < 200) begin @(negedge aclk); n++; end
    repeat (30) @(negedge aclk);
    chk("dbl_starts", 192'(n_start - s0), 192'd1);
    chk("dbl_dones", 192'(n_done - d0), 192'd1);
    rd_chk("dbl_done_reg", 8'h2C, 32'h1, 2'b00);
    rd_chk("start_readback", 8'h00, 32'h1, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
